// File: rtl/multi_channel_producer.sv
// multi_channel_producer: per-channel stall-aware {address, id, valid} beat source
// with a single-command programmable flush scheduler.
module multi_channel_producer #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 8,
  parameter int ID_W        = 8,
  parameter int TAG_W       = 4,
  parameter int SEQ_W       = ID_W - TAG_W,
  parameter int ADDR_STRIDE = 4,
  parameter int DLY_W       = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            in_stall,
  output logic [NUM_CH*ADDR_W-1:0]     out_address,
  output logic [NUM_CH*ID_W-1:0]       out_id,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic                         flush_cmd_valid,
  output logic                         flush_cmd_ready,
  input  logic [$clog2(NUM_CH+1)-1:0]  flush_cmd_ch,
  input  logic [ID_W-1:0]              flush_cmd_id,
  input  logic [DLY_W-1:0]             flush_cmd_delay,
  output logic [NUM_CH-1:0]            flush,
  output logic [NUM_CH*ID_W-1:0]       flush_id,
  output logic                         flush_err
);
  localparam int CH_W = $clog2(NUM_CH + 1);
  typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;
  state_t                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic [ID_W-1:0]         fid_q;
  logic [DLY_W-1:0]        cnt_q;
  logic [NUM_CH-1:0]       flush_q;
  logic [NUM_CH*ID_W-1:0]  flush_id_q;
  logic                    err_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic              adv;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              valid_q, valid_d;
    // a stalled channel holds its beat; an idle channel only drops valid
    always_comb begin
      adv     = ~in_stall[g] & ch_en[g];
      addr_d  = adv ? addr_q + ADDR_W'(ADDR_STRIDE) : addr_q;
      seq_d   = adv ? seq_q + SEQ_W'(1) : seq_q;
      id_d    = adv ? {TAG_W'(g + 1), seq_d} : id_q;
      valid_d = in_stall[g] ? valid_q : ch_en[g];
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        addr_q  <= '0;
        seq_q   <= '0;
        id_q    <= '0;
        valid_q <= 1'b0;
      end else begin
        addr_q  <= addr_d;
        seq_q   <= seq_d;
        id_q    <= id_d;
        valid_q <= valid_d;
      end
    assign out_address[g*ADDR_W +: ADDR_W] = addr_q;
    assign out_id[g*ID_W +: ID_W]          = id_q;
    assign out_valid[g]                    = valid_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      fid_q      <= '0;
      cnt_q      <= '0;
      flush_q    <= '0;
      flush_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (flush_cmd_valid) begin
          ch_q    <= flush_cmd_ch;
          fid_q   <= flush_cmd_id;
          cnt_q   <= flush_cmd_delay;
          state_q <= ARMED;
        end
        ARMED: if (cnt_q != '0) cnt_q <= cnt_q - DLY_W'(1);
        else begin
          state_q <= FIRE;
          err_q   <= ch_q >= CH_W'(NUM_CH);
          for (int c = 0; c < NUM_CH; c++) begin
            flush_q[c]                  <= ch_q == CH_W'(c);
            flush_id_q[c*ID_W +: ID_W]  <= ch_q == CH_W'(c) ? fid_q : '0;
          end
        end
        FIRE: begin
          state_q    <= IDLE;
          flush_q    <= '0;
          flush_id_q <= '0;
          err_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign flush_cmd_ready = state_q == IDLE;
  assign flush           = flush_q;
  assign flush_id        = flush_id_q;
  assign flush_err       = err_q;
endmodule

// File: tb/tb_multi_channel_producer.sv
// tb_multi_channel_producer: directed scoreboard bench for multi_channel_producer.
module tb_multi_channel_producer;
  localparam int NUM_CH = 2, ADDR_W = 8, ID_W = 8, TAG_W = 4, SEQ_W = 4, DLY_W = 6, CH_W = 2;
  logic clk = 0, reset = 1;
  logic [NUM_CH-1:0] ch_en = '0, in_stall = '0;
  logic [NUM_CH*ADDR_W-1:0] out_address;
  logic [NUM_CH*ID_W-1:0] out_id, flush_id;
  logic [NUM_CH-1:0] out_valid, flush;
  logic flush_cmd_valid = 0, flush_cmd_ready, flush_err;
  logic [CH_W-1:0] flush_cmd_ch = '0;
  logic [ID_W-1:0] flush_cmd_id = '0;
  logic [DLY_W-1:0] flush_cmd_delay = '0;

  multi_channel_producer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ID_W(ID_W), .TAG_W(TAG_W),
    .SEQ_W(SEQ_W), .ADDR_STRIDE(4), .DLY_W(DLY_W)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .in_stall(in_stall),
    .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
    .flush_cmd_valid(flush_cmd_valid), .flush_cmd_ready(flush_cmd_ready),
    .flush_cmd_ch(flush_cmd_ch), .flush_cmd_id(flush_cmd_id), .flush_cmd_delay(flush_cmd_delay),
    .flush(flush), .flush_id(flush_id), .flush_err(flush_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH*ADDR_W-1:0] a;
    logic [NUM_CH*ID_W-1:0]   id;
    logic [NUM_CH-1:0]        v;
    logic [NUM_CH-1:0]        f;
    logic [NUM_CH*ID_W-1:0]   fid;
    logic                     e;
    logic                     r;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  logic [ADDR_W-1:0] m_addr [NUM_CH];
  logic [SEQ_W-1:0]  m_seq  [NUM_CH];
  logic [ID_W-1:0]   m_id   [NUM_CH];
  logic              m_v    [NUM_CH];
  int cyc = 0, fire_cyc = 0;
  bit busy = 0;
  logic [CH_W-1:0] m_ch;
  logic [ID_W-1:0] m_fid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_addr[c] = '0; m_seq[c] = '0; m_id[c] = '0; m_v[c] = 0;
    end
    busy = 0;
  endtask

  task automatic step();
    exp_t e;
    logic rdy;
    rdy = !(busy && cyc <= fire_cyc);
    if (flush_cmd_valid && rdy) begin
      busy = 1; fire_cyc = cyc + int'(flush_cmd_delay) + 2; m_ch = flush_cmd_ch; m_fid = flush_cmd_id;
    end
    cyc++;
    e.f = '0; e.fid = '0; e.e = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!in_stall[c]) begin
        if (ch_en[c]) begin
          m_addr[c] = m_addr[c] + 8'd4;
          m_seq[c]  = m_seq[c] + 4'd1;
          m_id[c]   = {4'(c + 1), m_seq[c]};
          m_v[c]    = 1;
        end else m_v[c] = 0;
      end
      e.a[c*ADDR_W +: ADDR_W] = m_addr[c];
      e.id[c*ID_W +: ID_W]    = m_id[c];
      e.v[c]                  = m_v[c];
    end
    if (busy && cyc == fire_cyc) begin
      if (int'(m_ch) < NUM_CH) begin
        e.f[m_ch] = 1;
        e.fid[int'(m_ch)*ID_W +: ID_W] = m_fid;
      end else e.e = 1;
    end
    e.r = !(busy && cyc <= fire_cyc);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("address", out_address, e.a);
    chk("id", out_id, e.id);
    chk("valid", out_valid, e.v);
    chk("flush", flush, e.f);
    chk("flush_id", flush_id, e.fid);
    chk("flush_err", flush_err, e.e);
    chk("ready", flush_cmd_ready, e.r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, out_address, 0);
    chk({tag, "_id"}, out_id, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_flush_id"}, flush_id, 0);
    chk({tag, "_err"}, flush_err, 0);
  endtask

  initial begin
    int nf0, nf1, nerr;
    bit seen_a, seen_i;
    logic [7:0] pa, pid;
    model_reset();
    #2 chk_zero("rst");
    repeat (2) @(negedge clk);
    reset = 0;
    #1 chk("rst_ready", flush_cmd_ready, 1);

    // 1: free-running on both channels
    ch_en = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_addr0", out_address[7:0], 4 * (i + 1));
      chk("t1_id0", out_id[7:0], 8'h11 + i);
      chk("t1_id1", out_id[15:8], 8'h21 + i);
    end

    // 2: stall ch0 for 4 cycles
    in_stall = 2'b01;
    repeat (4) begin
      step();
      chk("t2_hold_id0", out_id[7:0], 8'h13);
      chk("t2_hold_v0", out_valid[0], 1);
    end
    in_stall = 2'b00;
    step();
    chk("t2_resume_id0", out_id[7:0], 8'h14);

    // disabled channel drops valid and holds state
    ch_en = 2'b10;
    repeat (2) step();
    chk("dis_v0", out_valid[0], 0);
    ch_en = 2'b11;
    step();
    chk("reen_id0", out_id[7:0], 8'h15);

    // 3: run past seq and address wrap
    seen_a = 0; seen_i = 0;
    repeat (66) begin
      pa = out_address[7:0]; pid = out_id[7:0];
      step();
      if (pid == 8'h1F) begin seen_i = 1; chk("t3_id_wrap", out_id[7:0], 8'h10); end
      if (pa == 8'hFC) begin seen_a = 1; chk("t3_addr_wrap", out_address[7:0], 0); end
    end
    chk("t3_wraps_seen", {seen_a, seen_i}, 2'b11);

    // 4: delayed flush, second command while busy is ignored
    nf0 = 0; nf1 = 0;
    flush_cmd_valid = 1; flush_cmd_ch = 0; flush_cmd_id = 8'h18; flush_cmd_delay = 3;
    step(); nf0 += flush[0];
    flush_cmd_valid = 0;
    step(); nf0 += flush[0];
    flush_cmd_valid = 1; flush_cmd_ch = 1; flush_cmd_id = 8'h55; flush_cmd_delay = 0;
    step(); nf0 += flush[0]; nf1 += flush[1];
    flush_cmd_valid = 0;
    repeat (5) begin step(); nf0 += flush[0]; nf1 += flush[1]; end
    chk("t4_flush0_once", nf0, 1);
    chk("t4_no_flush1", nf1, 0);

    // 5: zero delay, then out-of-range channel
    nf0 = 0; nerr = 0;
    flush_cmd_valid = 1; flush_cmd_ch = 0; flush_cmd_id = 8'h22; flush_cmd_delay = 0;
    step();
    flush_cmd_valid = 0;
    step();
    chk("t5_d0_flush", flush[0], 1);
    chk("t5_d0_fid", flush_id[7:0], 8'h22);
    repeat (2) step();
    nf0 = 0;
    flush_cmd_valid = 1; flush_cmd_ch = 2; flush_cmd_id = 8'h33; flush_cmd_delay = 1;
    step();
    flush_cmd_valid = 0;
    repeat (4) begin step(); nf0 += $countones(flush); nerr += flush_err; end
    chk("t5_err_once", nerr, 1);
    chk("t5_err_no_flush", nf0, 0);

    // 6: async reset while armed and mid-stream
    flush_cmd_valid = 1; flush_cmd_ch = 1; flush_cmd_id = 8'h44; flush_cmd_delay = 10;
    step();
    flush_cmd_valid = 0;
    repeat (3) step();
    @(negedge clk); #2 reset = 1;
    #1 chk_zero("t6_rst");
    model_reset();
    @(negedge clk); reset = 0;
    #1 chk("t6_ready", flush_cmd_ready, 1);
    nf1 = 0;
    repeat (15) begin step(); nf1 += $countones(flush); end
    chk("t6_no_stale_flush", nf1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
